uart_tx_ctl: RTL and testbench

UART transmit stage directly downstream of the SPI control block's TX FIFO. It pops 16-bit words from the TX FIFO and serialises each word as two UART frames, low byte first, on txd. Frame format and enable come from the 4-bit `state` control word; bit timing comes from the 16-bit `baud` divisor, both driven by the control register block.

---
 rtl/uart_tx_ctl.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_ctl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctl.sv
// UART transmit controller: pops 16-bit words from a synchronous-read TX FIFO
// and sends each as two UART frames, low byte first.
// Optional build macro: UART_TX_PARITY_EN compiles in the parity bit
// (state[1] enable, state[2] odd). Without it, frames are 8N1 or 8N2.
module uart_tx_ctl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned BAUD_MIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_fifo_data,
  input  logic              tx_fifo_empty,
  output logic              tx_fifo_rd,
  input  logic [3:0]        state,
  input  logic [15:0]       baud,
  output logic              txd,
  output logic              busy,
  output logic              word_done
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StLoad   = 3'd2,
    StStart  = 3'd3,
    StData   = 3'd4,
`ifdef UART_TX_PARITY_EN
    StParity = 3'd5,
`endif
    StStop   = 3'd6
  } tx_state_e;

  tx_state_e         r_state;
  logic [DATA_W-1:0] r_word;      // shifts right as bits go out; high byte follows low
  logic [15:0]       r_baud;      // latched effective clocks per bit
  logic [15:0]       r_cnt;       // per-bit down-counter
  logic [2:0]        r_bit_cnt;
  logic              r_byte_sel;
  logic              r_stop2;
  logic              r_stop_cnt;  // set while in the second stop bit
  logic              r_txd;
  logic              r_rd;
  logic              r_busy;
  logic              r_done;

  logic [15:0]       w_eff_baud;
  logic              w_bit_end;

`ifdef UART_TX_PARITY_EN
  logic              r_par_en;
  logic              r_par_odd;
  logic              r_par;       // running parity of the current byte, seeded with par_odd
`else
  logic              w_unused_par_cfg;
  assign w_unused_par_cfg = ^state[2:1];
`endif

  // Clamp the divisor so every bit lasts at least BAUD_MIN clocks.
  always_comb begin
    w_eff_baud = baud;
    if (baud < 16'(BAUD_MIN)) begin
      w_eff_baud = 16'(BAUD_MIN);
    end
  end

  assign w_bit_end = (r_cnt == 16'd0);

  // Main transmit FSM; all outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_word     <= '0;
      r_baud     <= '0;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_byte_sel <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_txd      <= 1'b1;
      r_rd       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_par      <= 1'b0;
`endif
    end else begin
      r_rd   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_txd <= 1'b1;
          if (state[0] && !tx_fifo_empty) begin
            r_state <= StFetch;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        StFetch: begin
          r_state <= StLoad;
        end
        StLoad: begin
          // FIFO read data is valid this cycle; config is frozen for the word.
          r_word     <= tx_fifo_data;
          r_baud     <= w_eff_baud;
          r_cnt      <= w_eff_baud - 16'd1;
          r_stop2    <= state[3];
`ifdef UART_TX_PARITY_EN
          r_par_en   <= state[1];
          r_par_odd  <= state[2];
`endif
          r_byte_sel <= 1'b0;
          r_txd      <= 1'b0;
          r_state    <= StStart;
        end
        StStart: begin
          if (w_bit_end) begin
            r_cnt     <= r_baud - 16'd1;
            r_bit_cnt <= 3'd0;
            r_txd     <= r_word[0];
`ifdef UART_TX_PARITY_EN
            r_par     <= r_par_odd ^ r_word[0];
`endif
            r_state   <= StData;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            r_cnt     <= r_baud - 16'd1;
            r_word    <= r_word >> 1;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (r_par_en) begin
                r_txd   <= r_par;
                r_state <= StParity;
              end else begin
                r_txd      <= 1'b1;
                r_stop_cnt <= 1'b0;
                r_state    <= StStop;
              end
`else
              r_txd      <= 1'b1;
              r_stop_cnt <= 1'b0;
              r_state    <= StStop;
`endif
            end else begin
              r_txd <= r_word[1];
`ifdef UART_TX_PARITY_EN
              r_par <= r_par ^ r_word[1];
`endif
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (w_bit_end) begin
            r_cnt      <= r_baud - 16'd1;
            r_txd      <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= StStop;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
`endif
        StStop: begin
          if (w_bit_end) begin
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
              r_cnt      <= r_baud - 16'd1;
            end else if (!r_byte_sel) begin
              // High byte follows immediately with no idle gap.
              r_byte_sel <= 1'b1;
              r_cnt      <= r_baud - 16'd1;
              r_txd      <= 1'b0;
              r_state    <= StStart;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign txd        = r_txd;
  assign tx_fifo_rd = r_rd;
  assign busy       = r_busy;
  assign word_done  = r_done;

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Directed self-checking bench for uart_tx_ctl with a synchronous-read FIFO model.
module tb_uart_tx_ctl;

`ifdef UART_TX_PARITY_EN
  localparam bit HasParity = 1'b1;
`else
  localparam bit HasParity = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tx_fifo_data = '0;
  logic        tx_fifo_empty = 1'b1;
  logic        tx_fifo_rd;
  logic [3:0]  state = 4'b0000;
  logic [15:0] baud = 16'd4;
  logic        txd;
  logic        busy;
  logic        word_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] fifo_q[$];
  logic        push_req = 1'b0;
  logic [15:0] push_data = '0;
  int          pops = 0;
  int          rd_when_empty = 0;
  bit          exp_bits[$];

  uart_tx_ctl #(
    .DATA_W   (16),
    .BAUD_MIN (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tx_fifo_data  (tx_fifo_data),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_fifo_rd    (tx_fifo_rd),
    .state         (state),
    .baud          (baud),
    .txd           (txd),
    .busy          (busy),
    .word_done     (word_done)
  );

  always #5 clk = ~clk;

  // FIFO model: pop data appears the cycle after tx_fifo_rd.
  always @(posedge clk) begin
    if (tx_fifo_rd) begin
      pops = pops + 1;
      if (fifo_q.size() == 0) begin
        rd_when_empty = rd_when_empty + 1;
      end else begin
        tx_fifo_data <= fifo_q.pop_front();
      end
    end
    if (push_req) fifo_q.push_back(push_data);
    tx_fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    push_data = w;
    push_req  = 1'b1;
    @(negedge clk);
    push_req  = 1'b0;
  endtask

  task automatic add_frame(input logic [7:0] b, input bit stop2, input bit par_en,
                           input bit par_odd);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    if (par_en) exp_bits.push_back((^b) ^ par_odd);
    exp_bits.push_back(1'b1);
    if (stop2) exp_bits.push_back(1'b1);
  endtask

  // Called at a negedge; waits for the start bit, then checks every cycle of both frames.
  task automatic expect_word(input logic [15:0] w, input int eff, input bit stop2,
                             input bit par_en, input bit par_odd);
    int t;
    int bad;
    exp_bits.delete();
    add_frame(w[7:0], stop2, par_en, par_odd);
    add_frame(w[15:8], stop2, par_en, par_odd);
    t = 0;
    while (txd !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("start_w%04h", w), {31'd0, txd}, 32'd0);
    for (int i = 0; i < exp_bits.size(); i++) begin
      bad = 0;
      for (int c = 0; c < eff; c++) begin
        if (txd !== exp_bits[i]) bad++;
        if (word_done !== 1'b0 || busy !== 1'b1) bad++;
        @(negedge clk);
      end
      check($sformatf("w%04h_bit%0d", w, i), bad, 0);
    end
    check($sformatf("done_w%04h", w), {30'd0, word_done, busy}, 32'b10);
  endtask

  initial begin
    int bad;
    int p0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, txd, tx_fifo_rd, busy, word_done}, 32'b1000);
    rst_n = 1'b1;

    // Idle with data but transmit disabled.
    push(16'hA55A);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0 || tx_fifo_rd !== 1'b0) bad++;
      @(negedge clk);
    end
    check("disabled_idle", bad, 0);
    check("disabled_pops", pops, 0);

    // 8N1, baud 4, latency from detection.
    baud  = 16'd4;
    state = 4'b0001;
    @(negedge clk);
    check("lat_rd_pulse", {31'd0, tx_fifo_rd}, 32'd1);
    @(negedge clk);
    check("lat_rd_low_txd_hi", {30'd0, tx_fifo_rd, txd}, 32'b01);
    @(negedge clk);
    check("lat_txd_fall", {31'd0, txd}, 32'd0);
    expect_word(16'hA55A, 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("single_word_done", {31'd0, word_done}, 32'd0);
    check("pops_after_w1", pops, 1);

    // Even then odd parity.
    state = 4'b0011;
    push(16'h0107);
    expect_word(16'h0107, 4, 1'b0, HasParity, 1'b0);
    state = 4'b0111;
    push(16'h0107);
    expect_word(16'h0107, 4, 1'b0, HasParity, 1'b1);

    // Clamped baud with two stop bits; baud change mid-word must not matter.
    state = 4'b1001;
    baud  = 16'd0;
    push(16'h3C81);
    fork
      expect_word(16'h3C81, 2, 1'b1, 1'b0, 1'b0);
      begin
        repeat (10) @(negedge clk);
        baud = 16'd7;
      end
    join

    // Back-to-back words, baud 3.
    state = 4'b0000;
    baud  = 16'd3;
    @(negedge clk);
    p0 = pops;
    push(16'h1234);
    push(16'hFEDC);
    state = 4'b0001;
    expect_word(16'h1234, 3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("gap_fetch", {31'd0, txd}, 32'd1);
    @(negedge clk);
    check("gap_load", {31'd0, txd}, 32'd1);
    @(negedge clk);
    check("gap_start", {31'd0, txd}, 32'd0);
    expect_word(16'hFEDC, 3, 1'b0, 1'b0, 1'b0);
    check("b2b_pops", pops - p0, 2);

    // Disable during low byte data: word still completes, no more pops.
    state = 4'b0000;
    baud  = 16'd4;
    @(negedge clk);
    p0 = pops;
    push(16'h6699);
    push(16'hBEEF);
    state = 4'b0001;
    fork
      expect_word(16'h6699, 4, 1'b0, 1'b0, 1'b0);
      begin
        repeat (14) @(negedge clk);
        state = 4'b0000;
      end
    join
    repeat (40) @(negedge clk);
    check("disable_pops", pops - p0, 1);
    check("disable_idle", {30'd0, busy, txd}, 32'b01);

    // Reset during the second word.
    state = 4'b0001;
    repeat (20) @(negedge clk);
    check("busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {29'd0, txd, busy, word_done}, 32'b100);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("post_rst_idle", bad, 0);
    check("post_rst_pops", pops - p0, 2);
    check("rd_when_empty", rd_when_empty, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
